food_ctrl: RTL and testbench

FOOD_CTRL -- requirements
Module: food_ctrl

---
 rtl/snek_pkg.sv | 36 +++
 rtl/food_lfsr.sv | 19 +
 rtl/food_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_food_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snek_pkg.sv
// Shared playfield geometry, widths, cell payload and food FSM encoding.
package snek_pkg;

    localparam int unsigned GRID_W    = 32;
    localparam int unsigned GRID_H    = 24;
    localparam int unsigned MAX_LEN   = 64;
    localparam int unsigned MAX_TRIES = 255;

    localparam int unsigned COORD_W   = 5;
    localparam int unsigned LEN_W     = 7;
    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned TRY_W     = 8;
    localparam int unsigned LFSR_W    = 2 * COORD_W;

    localparam logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAW   = 2'd1,
        ST_SCAN   = 2'd2,
        ST_COMMIT = 2'd3
    } food_state_t;

    // One playfield cell; the low half of a packed word is the column.
    typedef struct packed {
        logic [COORD_W-1:0] v;
        logic [COORD_W-1:0] h;
    } cell_t;

    // Limit a reported snake length to the depth of the segment table.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input int unsigned      max_len);
        return (len > LEN_W'(max_len)) ? LEN_W'(max_len) : len;
    endfunction

endpackage

// File: rtl/food_lfsr.sv
// Free-running 10-bit Fibonacci LFSR used as the food position source.
module food_lfsr
    import snek_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] state
);

    // x^10 + x^7 + 1: stage 10 xor stage 7 shifts in at the low end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LFSR_SEED;
        end else begin
            state <= {state[LFSR_W-2:0], state[LFSR_W-1] ^ state[6]};
        end
    end

endmodule

// File: rtl/food_ctrl.sv
// Food placement: draw a random cell, scan the snake body for a collision,
// and commit the first free in-grid cell; gives up after MAX_TRIES rejects.
module food_ctrl
    import snek_pkg::*;
#(
    parameter int unsigned GRID_W    = snek_pkg::GRID_W,
    parameter int unsigned GRID_H    = snek_pkg::GRID_H,
    parameter int unsigned MAX_LEN   = snek_pkg::MAX_LEN,
    parameter int unsigned MAX_TRIES = snek_pkg::MAX_TRIES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               eat,
    input  logic               restart,
    input  logic [LEN_W-1:0]   snake_len,
    output logic [ADDR_W-1:0]  seg_addr,
    input  logic [COORD_W-1:0] seg_h,
    input  logic [COORD_W-1:0] seg_v,
    output logic [COORD_W-1:0] food_h,
    output logic [COORD_W-1:0] food_v,
    output logic [COORD_W-1:0] cand_h,
    output logic [COORD_W-1:0] cand_v,
    output logic               food_valid,
    output logic               food_new,
    output logic               busy,
    output logic               place_fail
);

    localparam int unsigned CMP_W = COORD_W + 1;

    food_state_t        state_q, state_d;
    logic [LFSR_W-1:0]  lfsr;
    cell_t              lfsr_cell;
    cell_t              cand_q, cand_d;
    cell_t              food_q, food_d;
    logic               food_valid_q, food_valid_d;
    logic               food_new_q, food_new_d;
    logic               busy_q, busy_d;
    logic               place_fail_q, place_fail_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]  seg_addr_q, seg_addr_d;

    logic               off_grid_c;
    logic [LEN_W-1:0]   len_clamped_c;
    logic               hit_c;
    logic               last_c;
    logic               tries_last_c;

    food_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr)
    );

    // Candidate qualification and scan-compare terms shared by both comb blocks
    always_comb begin
        lfsr_cell     = cell_t'(lfsr);
        off_grid_c    = (CMP_W'(lfsr_cell.h) >= CMP_W'(GRID_W)) ||
                        (CMP_W'(lfsr_cell.v) >= CMP_W'(GRID_H));
        len_clamped_c = clamp_len(snake_len, MAX_LEN);
        // seg data lags seg_addr by one cycle, so index 0 has nothing to compare yet
        hit_c         = (state_q == ST_SCAN) && (idx_q != '0) &&
                        (seg_h == cand_q.h) && (seg_v == cand_q.v);
        last_c        = (idx_q == len_q);
        tries_last_c  = (tries_q == TRY_W'(MAX_TRIES - 1));
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_DRAW;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; restart overrides everything including eat
    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = ST_DRAW;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (eat) state_d = ST_DRAW;
                end
                ST_DRAW: begin
                    if (off_grid_c)                 state_d = tries_last_c ? ST_IDLE : ST_DRAW;
                    else if (len_clamped_c == '0)   state_d = ST_COMMIT;
                    else                            state_d = ST_SCAN;
                end
                ST_SCAN: begin
                    if (hit_c)       state_d = tries_last_c ? ST_IDLE : ST_DRAW;
                    else if (last_c) state_d = ST_COMMIT;
                end
                ST_COMMIT: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_DRAW;
                end
            endcase
        end
    end

    // Output/datapath next values; committed food is loaded on entry to COMMIT
    always_comb begin
        cand_d       = cand_q;
        food_d       = food_q;
        food_valid_d = food_valid_q;
        food_new_d   = 1'b0;
        place_fail_d = place_fail_q;
        tries_d      = tries_q;
        len_d        = len_q;
        idx_d        = idx_q;
        seg_addr_d   = seg_addr_q;
        busy_d       = (state_d != ST_IDLE);

        if (restart) begin
            food_valid_d = 1'b0;
            tries_d      = '0;
            place_fail_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (eat) begin
                        food_valid_d = 1'b0;
                        tries_d      = '0;
                        place_fail_d = 1'b0;
                    end
                end
                ST_DRAW: begin
                    cand_d = lfsr_cell;
                    if (off_grid_c) begin
                        if (tries_last_c) place_fail_d = 1'b1;
                        else              tries_d      = tries_q + TRY_W'(1);
                    end else begin
                        len_d      = len_clamped_c;
                        idx_d      = '0;
                        seg_addr_d = '0;
                        if (len_clamped_c == '0) begin
                            food_d       = lfsr_cell;
                            food_valid_d = 1'b1;
                            food_new_d   = 1'b1;
                        end
                    end
                end
                ST_SCAN: begin
                    if (hit_c) begin
                        if (tries_last_c) place_fail_d = 1'b1;
                        else              tries_d      = tries_q + TRY_W'(1);
                    end else if (last_c) begin
                        food_d       = cand_q;
                        food_valid_d = 1'b1;
                        food_new_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + LEN_W'(1);
                        if ((idx_q + LEN_W'(1)) < len_q) begin
                            seg_addr_d = ADDR_W'(idx_q + LEN_W'(1));
                        end
                    end
                end
                ST_COMMIT: begin
                    food_new_d = 1'b0;
                end
                default: begin
                    food_new_d = 1'b0;
                end
            endcase
        end
    end

    // Registered outputs and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_q       <= '0;
            food_q       <= '0;
            food_valid_q <= 1'b0;
            food_new_q   <= 1'b0;
            busy_q       <= 1'b1;
            place_fail_q <= 1'b0;
            tries_q      <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            seg_addr_q   <= '0;
        end else begin
            cand_q       <= cand_d;
            food_q       <= food_d;
            food_valid_q <= food_valid_d;
            food_new_q   <= food_new_d;
            busy_q       <= busy_d;
            place_fail_q <= place_fail_d;
            tries_q      <= tries_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            seg_addr_q   <= seg_addr_d;
        end
    end

    assign seg_addr   = seg_addr_q;
    assign cand_h     = cand_q.h;
    assign cand_v     = cand_q.v;
    assign food_h     = food_q.h;
    assign food_v     = food_q.v;
    assign food_valid = food_valid_q;
    assign food_new   = food_new_q;
    assign busy       = busy_q;
    assign place_fail = place_fail_q;

endmodule

// File: tb/tb_food_ctrl.sv
// Bench for food_ctrl: a transaction-level placement predictor walks the
// LFSR sequence forward and computes when and where food must appear.
module tb_food_ctrl;
    import snek_pkg::*;

    localparam int N_BLOCK = 200;
    localparam int N_RAND  = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        eat = 1'b0;
    logic        restart = 1'b0;
    logic [6:0]  snake_len = 7'd0;
    logic [5:0]  seg_addr;
    logic [4:0]  seg_h = 5'd0;
    logic [4:0]  seg_v = 5'd0;
    logic [4:0]  food_h, food_v, cand_h, cand_v;
    logic        food_valid, food_new, busy, place_fail;

    int n_checks = 0;
    int n_errors = 0;

    food_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .eat        (eat),
        .restart    (restart),
        .snake_len  (snake_len),
        .seg_addr   (seg_addr),
        .seg_h      (seg_h),
        .seg_v      (seg_v),
        .food_h     (food_h),
        .food_v     (food_v),
        .cand_h     (cand_h),
        .cand_v     (cand_v),
        .food_valid (food_valid),
        .food_new   (food_new),
        .busy       (busy),
        .place_fail (place_fail)
    );

    always #5 clk = ~clk;

    // Snake body: either a table read with one cycle latency, or an echo of the candidate
    int mem_h [64];
    int mem_v [64];
    bit echo = 1'b0;
    int cur_len = 0;

    always @(posedge clk) begin
        if (echo) begin
            seg_h <= cand_h;
            seg_v <= cand_v;
        end else begin
            seg_h <= 5'(mem_h[seg_addr]);
            seg_v <= 5'(mem_v[seg_addr]);
        end
    end

    // Reference random source: x^10 + x^7 + 1, seed 1, one step per clock
    function automatic logic [9:0] lfsr_next(input logic [9:0] s);
        return {s[8:0], s[9] ^ s[6]};
    endfunction

    logic [9:0] m_lfsr;
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= 10'h001;
        else      m_lfsr <= lfsr_next(m_lfsr);
    end

    // Prediction results, times relative to the first DRAW cycle
    int p_commit, p_idle, p_h, p_v;
    bit p_fail;
    int draw_q[$];

    function automatic int first_hit(input int h, input int v, input int len);
        if (echo) return 0;
        for (int i = 0; i < len; i++) begin
            if (mem_h[i] == h && mem_v[i] == v) return i;
        end
        return -1;
    endfunction

    function automatic bit is_draw(input int t);
        foreach (draw_q[i]) if (draw_q[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    // Placement outcome: an out-of-grid draw costs 1 cycle, a hit on segment k costs
    // k+3 cycles, a clean draw commits after len+2 cycles (1 when the body is empty)
    task automatic predict(input logic [9:0] l0, input int len_in);
        logic [9:0] l;
        int t;
        int len;
        int k;
        int cost;
        int rej;
        l = l0;
        t = 0;
        rej = 0;
        len = (len_in > int'(MAX_LEN)) ? int'(MAX_LEN) : len_in;
        p_fail = 1'b0;
        p_commit = -1;
        draw_q.delete();
        forever begin
            draw_q.push_back(t);
            k = -2;
            if (int'(l[4:0]) < int'(GRID_W) && int'(l[9:5]) < int'(GRID_H))
                k = first_hit(int'(l[4:0]), int'(l[9:5]), len);
            if (k == -1) begin
                p_commit = t + ((len == 0) ? 1 : len + 2);
                p_idle   = p_commit + 1;
                p_h      = int'(l[4:0]);
                p_v      = int'(l[9:5]);
                return;
            end
            rej++;
            cost = (k == -2) ? 1 : k + 3;
            for (int s = 0; s < cost; s++) l = lfsr_next(l);
            t += cost;
            if (rej == int'(MAX_TRIES)) begin
                p_fail = 1'b1;
                p_idle = t;
                return;
            end
        end
    endtask

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_eat();
        eat = 1'b1;
        step();
        eat = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_food_h"},     int'(food_h),     0);
        check({tag, "_food_v"},     int'(food_v),     0);
        check({tag, "_cand_h"},     int'(cand_h),     0);
        check({tag, "_cand_v"},     int'(cand_v),     0);
        check({tag, "_seg_addr"},   int'(seg_addr),   0);
        check({tag, "_food_valid"}, int'(food_valid), 0);
        check({tag, "_food_new"},   int'(food_new),   0);
        check({tag, "_place_fail"}, int'(place_fail), 0);
        check({tag, "_busy"},       int'(busy),       1);
    endtask

    // Called in the first DRAW cycle; follows the placement to its predicted end
    task automatic run_place(input string tag, input bit noise);
        int got_new;
        int n_new;
        int got_idle;
        got_new = -1;
        n_new = 0;
        got_idle = -1;
        snake_len = 7'(cur_len);
        predict(m_lfsr, cur_len);
        for (int t = 0; t <= p_idle; t++) begin
            if (food_new) begin
                n_new++;
                if (got_new < 0) got_new = t;
            end
            if (!busy && got_idle < 0) got_idle = t;
            if (t == p_idle) break;
            if (noise) begin
                snake_len = is_draw(t) ? 7'(cur_len) : 7'($urandom_range(0, 127));
                eat = ($urandom_range(0, 3) == 0);
            end
            step();
        end
        eat = 1'b0;
        snake_len = 7'(cur_len);
        check({tag, "_new_cycle"},  got_new,          p_fail ? -1 : p_commit);
        check({tag, "_new_count"},  n_new,            p_fail ? 0 : 1);
        check({tag, "_idle_cycle"}, got_idle,         p_idle);
        check({tag, "_valid"},      int'(food_valid), p_fail ? 0 : 1);
        check({tag, "_fail"},       int'(place_fail), int'(p_fail));
        if (!p_fail) begin
            check({tag, "_food_h"}, int'(food_h), p_h);
            check({tag, "_food_v"}, int'(food_v), p_v);
        end
    endtask

    initial begin
        int target;
        for (int i = 0; i < 64; i++) begin
            mem_h[i] = 3;
            mem_v[i] = 4;
        end

        // Reset values, then automatic first placement with an empty body
        rst = 1'b0;
        repeat (3) step();
        check_reset("rst");
        cur_len = 0;
        rst = 1'b1;
        run_place("boot", 1'b0);

        // Full-length body parked on (3,4)
        cur_len = 64;
        repeat (N_BLOCK) begin
            pulse_eat();
            run_place("blk", 1'b0);
            check("blk_not_3_4", int'(food_h == 5'd3 && food_v == 5'd4), 0);
        end

        // Random bodies and lengths, with eat and length noise while busy
        repeat (N_RAND) begin
            cur_len = $urandom_range(0, 100);
            for (int i = 0; i < 64; i++) begin
                mem_h[i] = $urandom_range(0, GRID_W - 1);
                mem_v[i] = $urandom_range(0, GRID_H - 1);
            end
            if ($urandom_range(0, 1) == 0) pulse_eat();
            else                           pulse_restart();
            run_place("rnd", 1'b1);
        end

        // Every candidate collides: exhaust the reject budget
        echo = 1'b1;
        cur_len = 1;
        snake_len = 7'd1;
        pulse_eat();
        run_place("exhaust", 1'b0);

        // eat with restart in IDLE: flags cleared, full budget available again
        eat = 1'b1;
        restart = 1'b1;
        step();
        eat = 1'b0;
        restart = 1'b0;
        check("er_place_fail", int'(place_fail), 0);
        check("er_valid",      int'(food_valid), 0);
        check("er_busy",       int'(busy),       1);
        run_place("er", 1'b0);

        // restart mid-placement resets the try counter
        pulse_eat();
        repeat (100) step();
        eat = 1'b1;
        restart = 1'b1;
        step();
        eat = 1'b0;
        restart = 1'b0;
        run_place("mid_restart", 1'b0);

        // One-cycle reset inside the final scan, then a fresh placement
        echo = 1'b0;
        for (int i = 0; i < 64; i++) begin
            mem_h[i] = 3;
            mem_v[i] = 4;
        end
        cur_len = 64;
        snake_len = 7'd64;
        pulse_eat();
        predict(m_lfsr, cur_len);
        target = p_commit - 10;
        repeat (target) step();
        rst = 1'b0;
        #1;
        check_reset("mid_rst");
        step();
        rst = 1'b1;
        run_place("post_rst", 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
